cxd2545_track_pulse_gen: RTL

//  Emulated-drive source of the track-crossing signal (SENS/TZC-style) that CXD2545_TRACK_COUNTER measures.
//  On a start command it emits N high pulses of programmed width and gap, all timed in prescaled ticks.

---
 rtl/cxd2545_pkg.sv | 25 ++
 rtl/cxd2545_tick_div.sv | 41 ++++
 rtl/cxd2545_track_pulse_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cxd2545_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cxd2545_pkg
//  Description : Shared definitions for the CXD2545 track-crossing blocks
//                (pulse generator and track counter): sequencer state
//                encoding and default field widths.
//  Revision    : 1.0  initial release
// ============================================================================
package cxd2545_pkg;

  // Default width of track count, pulse width and gap fields
  localparam int CNT_W_DEF = 16;
  // Default width of the prescaler divisor
  localparam int DIV_W_DEF = 16;

  // Pulse sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } track_state_t;

endpackage : cxd2545_pkg
`default_nettype wire

// File: rtl/cxd2545_tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : cxd2545_tick_div
//  Description : Prescaler producing one tick every div+1 clk cycles.
//                A new divisor is picked up at each wrap and on clear, so a
//                change never truncates or stretches the current period.
//  Revision    : 1.0  initial release
// ============================================================================
module cxd2545_tick_div
  import cxd2545_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;

  // Tick on the last count of the period
  assign tick = (r_cnt == r_div);

  // Period counter; divisor is sampled only at period boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
      r_div <= div;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule : cxd2545_tick_div
`default_nettype wire

// File: rtl/cxd2545_track_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cxd2545_track_pulse_gen
//  Description : Emits track_total high pulses on sens, each pulse_width ticks
//                high followed by pulse_gap ticks low, timed by a shared
//                prescaler. Supports abort and reports remaining tracks.
//  Revision    : 1.0  initial release
// ============================================================================
module cxd2545_track_pulse_gen
  import cxd2545_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] track_total,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] pulse_gap,
  output logic             sens,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tracks_left
);

  track_state_t     r_state, w_state_n;
  logic [CNT_W-1:0] r_phase, w_phase_n;
  logic [CNT_W-1:0] r_width, w_width_n;
  logic [CNT_W-1:0] r_gap,   w_gap_n;
  logic [CNT_W-1:0] r_left,  w_left_n;
  logic             r_sens,  w_sens_n;
  logic             r_busy,  w_busy_n;
  logic             r_done,  w_done_n;
  logic             w_clr;
  logic             w_tick;

  cxd2545_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .div  (div),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign sens        = r_sens;
  assign busy        = r_busy;
  assign done        = r_done;
  assign tracks_left = r_left;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_width <= CNT_W'(1);
      r_gap   <= CNT_W'(1);
      r_left  <= '0;
      r_sens  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_phase <= w_phase_n;
      r_width <= w_width_n;
      r_gap   <= w_gap_n;
      r_left  <= w_left_n;
      r_sens  <= w_sens_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  // Sequencer next-state and next-output logic
  always_comb begin
    w_state_n = r_state;
    w_phase_n = r_phase;
    w_width_n = r_width;
    w_gap_n   = r_gap;
    w_left_n  = r_left;
    w_sens_n  = r_sens;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_clr     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // abort is meaningless here; start alone decides
        if (start) begin
          w_clr     = 1'b1;
          w_busy_n  = 1'b1;
          w_phase_n = '0;
          w_left_n  = track_total;
          if (track_total != '0) begin
            w_width_n = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
            w_gap_n   = (pulse_gap   == '0) ? CNT_W'(1) : pulse_gap;
            w_sens_n  = 1'b1;
            w_state_n = ST_HIGH;
          end else begin
            w_state_n = ST_DONE;
            w_done_n  = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (abort) begin
          w_sens_n  = 1'b0;
          w_state_n = ST_DONE;
          w_done_n  = 1'b1;
        end else if (w_tick) begin
          if (r_phase == r_width - CNT_W'(1)) begin
            // HIGH is entered only with r_left >= 1, so no underflow
            w_sens_n  = 1'b0;
            w_left_n  = r_left - CNT_W'(1);
            w_phase_n = '0;
            w_state_n = ST_LOW;
          end else begin
            w_phase_n = r_phase + CNT_W'(1);
          end
        end
      end

      ST_LOW: begin
        if (abort) begin
          w_sens_n  = 1'b0;
          w_state_n = ST_DONE;
          w_done_n  = 1'b1;
        end else if (w_tick) begin
          if (r_phase == r_gap - CNT_W'(1)) begin
            w_phase_n = '0;
            if (r_left == '0) begin
              w_state_n = ST_DONE;
              w_done_n  = 1'b1;
            end else begin
              w_sens_n  = 1'b1;
              w_state_n = ST_HIGH;
            end
          end else begin
            w_phase_n = r_phase + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        // done strobe was registered on entry; release busy and go idle
        w_busy_n  = 1'b0;
        w_state_n = ST_IDLE;
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

endmodule : cxd2545_track_pulse_gen
`default_nettype wire
